packet_identifier: RTL and testbench

Physical-layer receive-side framing identifier for a 64-byte-wide (512-bit) datapath. Each cycle it scans the incoming symbol word for 8b/10b framing K-symbols (STP, SDP, END, EDB) and emits per-byte masks marking valid packet bytes and TLP/DLLP start and end positions. It tracks packets that span cycles. It sits between the descrambled/decoded lane data and the data-link layer receive logic.

---
 rtl/pl_pkg.sv | 15 +
 rtl/pi_symbol_decode.sv | 16 +
 rtl/packet_identifier.sv | 107 ++++++++++
 tb/tb_packet_identifier.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pl_pkg.sv
// pl_pkg: shared framing symbol codes, generation encodings and datapath widths
package pl_pkg;
    localparam int PL_BYTES = 64;
    localparam int PL_W     = 512;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [2:0] GEN1 = 3'b000;
    localparam logic [2:0] GEN2 = 3'b001;

    function automatic logic gen_ok(input logic [2:0] g);
        return g == GEN1 || g == GEN2;
    endfunction
endpackage

// File: rtl/pi_symbol_decode.sv
// pi_symbol_decode: classifies one symbol byte as a framing K-symbol (one-hot)
module pi_symbol_decode
    import pl_pkg::*;
(
    input  logic [7:0] data,
    input  logic       k,
    output logic       is_stp,
    output logic       is_sdp,
    output logic       is_end,
    output logic       is_edb
);
    assign is_stp = k && data == K_STP;
    assign is_sdp = k && data == K_SDP;
    assign is_end = k && data == K_END;
    assign is_edb = k && data == K_EDB;
endmodule

// File: rtl/packet_identifier.sv
// packet_identifier: per-byte TLP/DLLP framing masks for a 64-byte receive word,
// tracking packets that span words.
module packet_identifier
    import pl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PL_W-1:0]     data_in,
    input  logic [PL_BYTES-1:0] DK,
    input  logic                valid_pd,
    input  logic                linkup,
    input  logic [2:0]          gen,
    output logic [PL_W-1:0]     data_out,
    output logic [PL_BYTES-1:0] pl_valid,
    output logic [PL_BYTES-1:0] pl_tlpstart,
    output logic [PL_BYTES-1:0] pl_dlpstart,
    output logic [PL_BYTES-1:0] pl_tlpend,
    output logic [PL_BYTES-1:0] pl_tlpedb,
    output logic [PL_BYTES-1:0] pl_dlpend,
    output logic                w
);
    logic [PL_BYTES-1:0] is_stp, is_sdp, is_end, is_edb;
    logic [PL_BYTES-1:0] n_valid, n_tstart, n_dstart, n_tend, n_tedb, n_dend;
    logic in_pkt, pkt_tlp, n_in, n_tlp;

    for (genvar i = 0; i < PL_BYTES; i++) begin : g_dec
        pi_symbol_decode u_dec (
            .data   (data_in[8*i +: 8]),
            .k      (DK[i]),
            .is_stp (is_stp[i]),
            .is_sdp (is_sdp[i]),
            .is_end (is_end[i]),
            .is_edb (is_edb[i])
        );
    end

    // Ripple the packet state through the word, byte 0 first.
    always_comb begin
        n_valid  = '0;
        n_tstart = '0;
        n_dstart = '0;
        n_tend   = '0;
        n_tedb   = '0;
        n_dend   = '0;
        n_in     = in_pkt;
        n_tlp    = pkt_tlp;
        for (int i = 0; i < PL_BYTES; i++) begin
            if (is_stp[i]) begin
                n_tstart[i] = 1'b1;
                n_valid[i]  = 1'b1;
                n_in        = 1'b1;
                n_tlp       = 1'b1;
            end else if (is_sdp[i]) begin
                n_dstart[i] = 1'b1;
                n_valid[i]  = 1'b1;
                n_in        = 1'b1;
                n_tlp       = 1'b0;
            end else if (is_end[i]) begin
                n_valid[i] = n_in;
                n_tend[i]  = n_in && n_tlp;
                n_dend[i]  = n_in && !n_tlp;
                n_in       = 1'b0;
            end else if (is_edb[i]) begin
                // EDB inside a DLLP is an abort: no valid byte, no end flag.
                n_valid[i] = n_in && n_tlp;
                n_tedb[i]  = n_in && n_tlp;
                n_in       = 1'b0;
            end else begin
                n_valid[i] = n_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !linkup) begin
            data_out    <= '0;
            pl_valid    <= '0;
            pl_tlpstart <= '0;
            pl_dlpstart <= '0;
            pl_tlpend   <= '0;
            pl_tlpedb   <= '0;
            pl_dlpend   <= '0;
            in_pkt      <= 1'b0;
            pkt_tlp     <= 1'b0;
        end else if (!valid_pd) begin
            pl_valid    <= '0;
            pl_tlpstart <= '0;
            pl_dlpstart <= '0;
            pl_tlpend   <= '0;
            pl_tlpedb   <= '0;
            pl_dlpend   <= '0;
        end else begin
            data_out    <= data_in;
            pl_valid    <= gen_ok(gen) ? n_valid : '0;
            pl_tlpstart <= gen_ok(gen) ? n_tstart : '0;
            pl_dlpstart <= gen_ok(gen) ? n_dstart : '0;
            pl_tlpend   <= gen_ok(gen) ? n_tend : '0;
            pl_tlpedb   <= gen_ok(gen) ? n_tedb : '0;
            pl_dlpend   <= gen_ok(gen) ? n_dend : '0;
            in_pkt      <= gen_ok(gen) && n_in;
            pkt_tlp     <= gen_ok(gen) && n_tlp;
        end
    end

    // The open-packet flag after byte 63 is exactly the continuation indicator.
    assign w = in_pkt;
endmodule

// File: tb/tb_packet_identifier.sv
// tb_packet_identifier: directed table-driven checks of packet_identifier framing masks
module tb_packet_identifier;
    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] data_in;
    logic [63:0]  DK;
    logic         valid_pd, linkup;
    logic [2:0]   gen;
    logic [511:0] data_out;
    logic [63:0]  pl_valid, pl_tlpstart, pl_dlpstart, pl_tlpend, pl_tlpedb, pl_dlpend;
    logic         w;

    packet_identifier dut (
        .clk(clk), .rst(rst), .data_in(data_in), .DK(DK), .valid_pd(valid_pd),
        .linkup(linkup), .gen(gen), .data_out(data_out), .pl_valid(pl_valid),
        .pl_tlpstart(pl_tlpstart), .pl_dlpstart(pl_dlpstart), .pl_tlpend(pl_tlpend),
        .pl_tlpedb(pl_tlpedb), .pl_dlpend(pl_dlpend), .w(w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         vpd, lu;
        logic [2:0]   g;
        logic [63:0]  ev, ets, eds, ete, eeb, ede;
        logic         ew;
        logic [511:0] edo;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ev, ets, eds, ete, eeb, ede,
                             input logic ew, input logic [511:0] edo);
        chk({tag, " pl_valid"}, {448'b0, pl_valid}, {448'b0, ev});
        chk({tag, " pl_tlpstart"}, {448'b0, pl_tlpstart}, {448'b0, ets});
        chk({tag, " pl_dlpstart"}, {448'b0, pl_dlpstart}, {448'b0, eds});
        chk({tag, " pl_tlpend"}, {448'b0, pl_tlpend}, {448'b0, ete});
        chk({tag, " pl_tlpedb"}, {448'b0, pl_tlpedb}, {448'b0, eeb});
        chk({tag, " pl_dlpend"}, {448'b0, pl_dlpend}, {448'b0, ede});
        chk({tag, " w"}, {511'b0, w}, {511'b0, ew});
        chk({tag, " data_out"}, data_out, edo);
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [511:0] put(input logic [511:0] d, input int i, input logic [7:0] b);
        d[8*i +: 8] = b;
        return d;
    endfunction

    function automatic logic [63:0] bit1(input int i);
        logic [63:0] m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic add(input logic [511:0] d, input logic [63:0] k, input logic vpd, lu,
                       input logic [2:0] g, input logic [63:0] ev, ets, eds, ete, eeb, ede,
                       input logic ew, input logic [511:0] edo);
        vec_t v;
        v.d = d; v.k = k; v.vpd = vpd; v.lu = lu; v.g = g;
        v.ev = ev; v.ets = ets; v.eds = eds; v.ete = ete; v.eeb = eeb; v.ede = ede;
        v.ew = ew; v.edo = edo;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [511:0] d, input logic [63:0] k, input logic vpd, lu,
                         input logic [2:0] g);
        data_in = d; DK = k; valid_pd = vpd; linkup = lu; gen = g;
    endtask

    initial begin
        logic [511:0] d, d7, dm;
        logic [63:0] k;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) data_in[32*i +: 32] = $urandom;
        DK = {$urandom, $urandom};
        valid_pd = 1'b1; linkup = 1'b1; gen = 3'b000;
        repeat (2) @(posedge clk);
        #1 check_all("reset", '0, '0, '0, '0, '0, '0, 1'b0, '0);
        rst = 1'b0;

        // single TLP in one word
        d = '0;
        d = put(d, 0, 8'hFB);
        for (int i = 1; i < 15; i++) d = put(d, i, 8'(8'h10 + i));
        d = put(d, 15, 8'hFD);
        add(d, 64'h8001, 1, 1, 3'b000, 64'hFFFF, 64'h1, 0, 64'h8000, 0, 0, 0, d);
        // DLLP spanning two words
        d = put('0, 60, 8'h5C);
        add(d, bit1(60), 1, 1, 3'b000, 64'hF000_0000_0000_0000, 0, bit1(60), 0, 0, 0, 1, d);
        d = put(put('0, 0, 8'h12), 1, 8'hFD);
        add(d, bit1(1), 1, 1, 3'b000, 64'h3, 0, 0, 0, 0, bit1(1), 0, d);
        // nullified TLP
        d = put(put('0, 0, 8'hFB), 8, 8'hFE);
        add(d, 64'h101, 1, 1, 3'b000, 64'h1FF, 64'h1, 0, 0, 64'h100, 0, 0, d);
        // stray END while idle
        d = put('0, 5, 8'hFD);
        add(d, bit1(5), 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, d);
        // FB as a data byte is not a start
        d = put(put(put('0, 0, 8'hFB), 3, 8'hFB), 4, 8'hFD);
        add(d, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, d);
        // TLP opens at byte 62, valid_pd drops, then it closes
        d7 = put(put('0, 62, 8'hFB), 63, 8'hAA);
        add(d7, bit1(62), 1, 1, 3'b000, rng(62, 63), bit1(62), 0, 0, 0, 0, 1, d7);
        d = put('0, 0, 8'hFD);
        add(d, bit1(0), 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, d7);
        d = put(put('0, 0, 8'h33), 2, 8'hFD);
        add(d, bit1(2), 1, 1, 3'b000, 64'h7, 0, 0, bit1(2), 0, 0, 0, d);
        // many packets in one word: abort, abandon, nullify
        dm = '0; k = '0;
        dm = put(dm, 0, 8'hFB);  dm = put(dm, 3, 8'hFD);  dm = put(dm, 4, 8'h5C);
        dm = put(dm, 10, 8'hFD); dm = put(dm, 20, 8'hFB); dm = put(dm, 30, 8'hFE);
        dm = put(dm, 40, 8'h5C); dm = put(dm, 45, 8'hFE); dm = put(dm, 50, 8'hFB);
        dm = put(dm, 51, 8'h5C); dm = put(dm, 55, 8'hFD);
        foreach (k[i]) k[i] = (i inside {0, 3, 4, 10, 20, 30, 40, 45, 50, 51, 55});
        add(dm, k, 1, 1, 3'b001,
            rng(0, 10) | rng(20, 30) | rng(40, 44) | rng(50, 55),
            bit1(0) | bit1(20) | bit1(50), bit1(4) | bit1(40) | bit1(51),
            bit1(3), bit1(30), bit1(10) | bit1(55), 0, dm);
        // reserved gen mid-packet clears state
        d = put('0, 63, 8'hFB);
        add(d, bit1(63), 1, 1, 3'b000, bit1(63), bit1(63), 0, 0, 0, 0, 1, d);
        d = put('0, 0, 8'h44);
        add(d, 0, 1, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, d);
        d = put(put('0, 0, 8'h55), 1, 8'hFD);
        add(d, bit1(1), 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, d);
        // linkup low mid-packet clears state and data_out
        d = put('0, 63, 8'h5C);
        add(d, bit1(63), 1, 1, 3'b000, bit1(63), 0, bit1(63), 0, 0, 0, 1, d);
        d = put('0, 0, 8'h66);
        add(d, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, '0);
        d = put(put('0, 0, 8'h77), 2, 8'hFD);
        add(d, bit1(2), 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, d);
        // non-framing K (COM) inside a packet stays valid
        d = put(put(put('0, 0, 8'hFB), 1, 8'hBC), 2, 8'hFD);
        add(d, 64'h7, 1, 1, 3'b001, 64'h7, 64'h1, 0, 64'h4, 0, 0, 0, d);
        // new start abandons a packet carried over from the previous word
        d = put('0, 63, 8'hFB);
        add(d, bit1(63), 1, 1, 3'b000, bit1(63), bit1(63), 0, 0, 0, 0, 1, d);
        d = put(put('0, 0, 8'h5C), 1, 8'hFD);
        add(d, 64'h3, 1, 1, 3'b000, 64'h3, 0, 64'h1, 0, 0, 64'h2, 0, d);

        foreach (vq[n]) begin
            drive(vq[n].d, vq[n].k, vq[n].vpd, vq[n].lu, vq[n].g);
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", n), vq[n].ev, vq[n].ets, vq[n].eds, vq[n].ete,
                         vq[n].eeb, vq[n].ede, vq[n].ew, vq[n].edo);
        end

        // reset overrides an open packet
        d = put('0, 63, 8'hFB);
        drive(d, bit1(63), 1, 1, 3'b000);
        @(posedge clk);
        #1 check_all("rst_pre", bit1(63), bit1(63), 0, 0, 0, 0, 1, d);
        rst = 1'b1;
        drive(put('0, 0, 8'hFD), bit1(0), 1, 1, 3'b000);
        @(posedge clk);
        #1 check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, '0);
        rst = 1'b0;
        d = put(put('0, 0, 8'h21), 1, 8'hFD);
        drive(d, bit1(1), 1, 1, 3'b000);
        @(posedge clk);
        #1 check_all("rst_post", 0, 0, 0, 0, 0, 0, 0, d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
